// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and pointer sizing helpers
// used by the synchronous and asynchronous FIFOs.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // One extra bit beyond the address lets full and empty be told apart.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFOs: one clocked write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level count, programmable almost-full/almost-empty,
// sticky overflow/underflow and a selectable standard or first-word-fall-through read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] AF_LEVEL = (PTR_WIDTH + 1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_LEVEL = (PTR_WIDTH + 1)'(AE_THRESH);

  logic [PTR_WIDTH:0]    wptr;
  logic [PTR_WIDTH:0]    rptr;
  logic [PTR_WIDTH:0]    level;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags come only from the registered pointers, never from wr_en/rd_en.
  assign level        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                        (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign count        = level;
  assign almost_full  = (level >= AF_LEVEL);
  assign almost_empty = (level <= AE_LEVEL);

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // A fresh error in the same cycle as err_clr stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr[PTR_WIDTH-1:0]),
    .wdata (wr_data),
    .raddr (rptr[PTR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Gated to zero while empty so the output is defined straight out of reset.
      assign rd_data = empty ? '0 : ram_rdata;
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data <= '0;
        end else if (rd_ok) begin
          rd_data <= ram_rdata;
        end
      end
    end
  endgenerate

endmodule
